// File: rtl/regfile_access_sequencer.sv
// Sequences one instruction's register-file traffic: optional writeback, two
// operand reads, then holds both operands until the consumer takes them.
module regfile_access_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wb_en,
  input  logic [DATA_W-1:0] req_wb_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_op_a,
  output logic [DATA_W-1:0] rsp_op_b,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_value,
  output logic              rf_write,
  output logic              rf_read,
  output logic              rf_reset,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WB, S_RD_A, S_RD_B, S_CAP_B, S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_rf_address;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_wb_data;
  logic [ADDR_W-1:0]   r_addr_hold;
  logic [DATA_W-1:0]   r_value_hold;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;

  assign req_ready = (r_state == S_IDLE) && !clr_req;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_op_a  = r_op_a;
  assign rsp_op_b  = r_op_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    rf_write     = 1'b0;
    rf_read      = 1'b0;
    rf_reset     = 1'b0;
    w_rf_address = r_addr_hold;
    rf_value     = r_value_hold;
    case (r_state)
      S_IDLE: begin
        // A clear request pre-empts any request offered in the same cycle.
        if (clr_req)       w_state_nxt = S_CLEAR;
        else if (w_accept) w_state_nxt = req_wb_en ? S_WB : S_RD_A;
      end
      S_CLEAR: begin
        rf_reset    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_WB: begin
        rf_write     = 1'b1;
        w_rf_address = r_rd;
        rf_value     = r_wb_data;
        w_state_nxt  = S_RD_A;
      end
      S_RD_A: begin
        rf_read      = 1'b1;
        w_rf_address = r_rs1;
        w_state_nxt  = S_RD_B;
      end
      S_RD_B: begin
        rf_read      = 1'b1;
        w_rf_address = r_rs2;
        w_state_nxt  = S_CAP_B;
      end
      S_CAP_B: w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rf_address = w_rf_address;

  // Read data lags the read strobe by one cycle, so operand A lands during
  // RD_B and operand B during CAP_B.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_wb_data    <= '0;
      r_addr_hold  <= '0;
      r_value_hold <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
    end else begin
      r_addr_hold  <= w_rf_address;
      r_value_hold <= rf_value;
      if (w_accept) begin
        r_rs1     <= req_rs1;
        r_rs2     <= req_rs2;
        r_rd      <= req_rd;
        r_wb_data <= req_wb_data;
      end
      if (r_state == S_RD_B)  r_op_a <= rf_data_out;
      if (r_state == S_CAP_B) r_op_b <= rf_data_out;
    end
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for regfile_access_sequencer with a behavioural 16x32 register file.
module tb_regfile_access_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wb_en;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic [31:0] req_wb_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_op_a, rsp_op_b;
  logic        clr_req, busy;
  logic [3:0]  rf_address;
  logic [31:0] rf_value, rf_data_out;
  logic        rf_write, rf_read, rf_reset;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int clr_cnt  = 0;

  logic [31:0] mem [16];

  always #5 clock = ~clock;

  regfile_access_sequencer #(.ADDR_W(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_wb_en(req_wb_en), .req_wb_data(req_wb_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op_a(rsp_op_a), .rsp_op_b(rsp_op_b),
    .clr_req(clr_req), .busy(busy),
    .rf_address(rf_address), .rf_value(rf_value),
    .rf_write(rf_write), .rf_read(rf_read), .rf_reset(rf_reset),
    .rf_data_out(rf_data_out)
  );

  // Register file: reset > write > read, read data one cycle later.
  always @(posedge clock) begin
    if (rf_reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
      clr_cnt <= clr_cnt + 1;
    end else if (rf_write) begin
      mem[rf_address] <= rf_value;
      wr_cnt <= wr_cnt + 1;
    end else if (rf_read) begin
      rf_data_out <= mem[rf_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offers one request, returns in the first cycle rsp_valid is high.
  task automatic do_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic wb, input logic [31:0] data, output int lat,
                        output logic first_wr, output logic [3:0] first_addr);
    int n;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_wb_en = wb; req_wb_data = data; req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid  = 1'b0;
    first_wr   = rf_write;
    first_addr = rf_address;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    chk("rsp_valid_reached", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic        fw;
    logic [3:0]  fa;
    int          wr_before;

    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    req_wb_en = 1'b0; req_wb_data = '0; rsp_ready = 1'b1; clr_req = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {29'd0, rf_write, rf_read, rf_reset}, 32'd0);
    chk("rst_rf_address", {28'd0, rf_address}, 32'd0);
    chk("rst_rf_value", rf_value, 32'd0);
    chk("rst_op_a", rsp_op_a, 32'd0);
    chk("rst_op_b", rsp_op_b, 32'd0);
    clr_req = 1'b1; #1;
    chk("rst_req_ready_clr", {31'd0, req_ready}, 32'd0);
    clr_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;

    // Clear then read
    clr_req = 1'b1; #1;
    chk("clr_req_ready", {31'd0, req_ready}, 32'd0);
    step(); clr_req = 1'b0;
    chk("clr_rf_reset_on", {31'd0, rf_reset}, 32'd1);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    step();
    chk("clr_rf_reset_off", {31'd0, rf_reset}, 32'd0);
    chk("clr_pulse_count", clr_cnt, 32'd1);
    do_req(4'd3, 4'd7, 4'd0, 1'b0, 32'h0, lat, fw, fa);
    chk("clr_lat", lat, 32'd4);
    chk("clr_op_a", rsp_op_a, 32'd0);
    chk("clr_op_b", rsp_op_b, 32'd0);
    step();

    // Writeback with read-after-write on rs1
    do_req(4'd5, 4'd0, 4'd5, 1'b1, 32'hDEADBEEF, lat, fw, fa);
    chk("wb_first_write", {31'd0, fw}, 32'd1);
    chk("wb_first_addr", {28'd0, fa}, 32'd5);
    chk("wb_lat", lat, 32'd5);
    chk("wb_op_a", rsp_op_a, 32'hDEADBEEF);
    chk("wb_op_b", rsp_op_b, 32'd0);
    step();
    chk("wb_back_idle", {31'd0, busy}, 32'd0);

    // Back-pressure
    rsp_ready = 1'b0;
    do_req(4'd1, 4'd5, 4'd0, 1'b0, 32'h0, lat, fw, fa);
    chk("bp_lat", lat, 32'd4);
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_op_a", rsp_op_a, 32'd0);
      chk("bp_op_b", rsp_op_b, 32'hDEADBEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_strobes", {29'd0, rf_write, rf_read, rf_reset}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Clear versus request collision
    req_rs1 = 4'd5; req_rs2 = 4'd5; req_rd = 4'd0; req_wb_en = 1'b0;
    req_valid = 1'b1; clr_req = 1'b1; #1;
    chk("col_req_ready", {31'd0, req_ready}, 32'd0);
    step(); clr_req = 1'b0;
    chk("col_rf_reset", {31'd0, rf_reset}, 32'd1);
    chk("col_req_ready_clear", {31'd0, req_ready}, 32'd0);
    step();
    chk("col_req_ready_after", {31'd0, req_ready}, 32'd1);
    do_req(4'd5, 4'd5, 4'd0, 1'b0, 32'h0, lat, fw, fa);
    chk("col_op_a", rsp_op_a, 32'd0);
    chk("col_op_b", rsp_op_b, 32'd0);
    step();

    // Reset mid-sequence
    do_req(4'd9, 4'd9, 4'd9, 1'b1, 32'h12345678, lat, fw, fa);
    chk("pre_rst_op_a", rsp_op_a, 32'h12345678);
    step();
    wr_before = wr_cnt;
    req_rs1 = 4'd9; req_rs2 = 4'd9; req_rd = 4'd9; req_wb_en = 1'b1;
    req_wb_data = 32'hBAD0BAD0; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    chk("mid_in_wb", {31'd0, rf_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rf_write", {31'd0, rf_write}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rf_address", {28'd0, rf_address}, 32'd0);
    chk("mid_rf_value", rf_value, 32'd0);
    chk("mid_op_a", rsp_op_a, 32'd0);
    step();
    reset = 1'b0; #1;
    chk("mid_no_write", wr_cnt, wr_before);
    do_req(4'd9, 4'd9, 4'd0, 1'b0, 32'h0, lat, fw, fa);
    chk("mid_old_a", rsp_op_a, 32'h12345678);
    chk("mid_old_b", rsp_op_b, 32'h12345678);
    step();

    // Regression over all registers
    for (int i = 0; i < 16; i++) begin
      do_req(4'(i), 4'(i), 4'(i), 1'b1, 32'(i) * 32'h01010101, lat, fw, fa);
      chk("reg_wb_lat", lat, 32'd5);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      do_req(4'(i), 4'(15 - i), 4'd0, 1'b0, 32'h0, lat, fw, fa);
      chk("reg_op_a", rsp_op_a, 32'(i) * 32'h01010101);
      chk("reg_op_b", rsp_op_b, 32'(15 - i) * 32'h01010101);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
